// File: rtl/dm_access_pkg.sv
// -----------------------------------------------------------------------------
// dm_access_pkg
// Shared definitions for the data-memory access controller:
//   - op_e    : request operation codes (loads 0..4, stores 5..7)
//   - state_e : sequencer states
//   - is_store / is_misaligned helper functions
// -----------------------------------------------------------------------------
package dm_access_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RSP  = 2'd3
    } state_e;

    function automatic logic is_store(input logic [2:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    // Halfwords need an even address, words need a 4-byte aligned address.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
        logic half_op;
        logic word_op;
        half_op = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
        word_op = (op == OP_LW) || (op == OP_SW);
        return (half_op && off[0]) || (word_op && (off != 2'b00));
    endfunction

endpackage

// File: rtl/dm_lane_mux.sv
// -----------------------------------------------------------------------------
// dm_lane_mux
// Purely combinational byte-lane steering for sub-word accesses.
// Lanes are little-endian: byte offset k occupies bits [8k+7:8k].
// Ports:
//   op_i     [2:0]  operation code (dm_access_pkg::op_e)
//   off_i    [1:0]  byte offset within the word (addr[1:0])
//   word_i   [31:0] word read from memory
//   wdata_i  [31:0] right-aligned store data
//   load_o   [31:0] selected and sign/zero-extended load result
//   store_o  [31:0] read word with the store lanes replaced
// -----------------------------------------------------------------------------
module dm_lane_mux
    import dm_access_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{off_i, 3'b000} +: 8];
        // Halfword accesses are already known to be even, so only off_i[1] matters.
        half_sel = word_i[{off_i[1], 4'b0000} +: 16];

        load_o = word_i;
        case (op_e'(op_i))
            OP_LH:   load_o = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_o = {16'h0000, half_sel};
            OP_LB:   load_o = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_o = {24'h000000, byte_sel};
            default: load_o = word_i;
        endcase

        store_o = word_i;
        case (op_e'(op_i))
            OP_SB:   store_o[{off_i, 3'b000} +: 8]     = wdata_i[7:0];
            OP_SH:   store_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            OP_SW:   store_o = wdata_i;
            default: store_o = word_i;
        endcase
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// -----------------------------------------------------------------------------
// dm_access_ctrl
// Two-port round-robin arbiter and access sequencer in front of a single-port,
// word-wide data memory with combinational read and clocked whole-word write.
// Sub-word stores are done as read-modify-write; misaligned requests are
// answered with rsp_err and never touch memory.
//
// Handshake: a request on port i is accepted in the cycle where req_valid[i]
// and req_ready[i] are both high; req_ready is a combinational one-cycle pulse
// and the request fields are don't-care afterwards. rsp_valid[i] is a
// one-cycle pulse with no backpressure; rsp_rdata/rsp_err are meaningful only
// in that cycle.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid[1:0]           per-port request valid (0 = CPU, 1 = debug)
//   req_addrN/opN/wdataN     per-port byte address, op code, store data
//   req_ready[1:0]           accept pulse
//   rsp_valid[1:0]           response pulse to the owning port
//   rsp_rdata, rsp_err       load result / misaligned flag
//   mem_addr, mem_din, mem_we, mem_dout   memory interface
//   dbg_state[1:0]           current sequencer state (state_e encoding)
// Optional build macro DM_ACCESS_CTRL_STATS_EN adds saturating 16-bit
// counters stat_acc0, stat_acc1 (completed accesses per port) and
// stat_conflict (IDLE cycles with both ports requesting).
// -----------------------------------------------------------------------------
module dm_access_ctrl
    import dm_access_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req_valid,
    input  logic [AW-1:0] req_addr0,
    input  logic [AW-1:0] req_addr1,
    input  logic [2:0]    req_op0,
    input  logic [2:0]    req_op1,
    input  logic [DW-1:0] req_wdata0,
    input  logic [DW-1:0] req_wdata1,
    output logic [1:0]    req_ready,
    output logic [1:0]    rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dout,
    output logic [1:0]    dbg_state
`ifdef DM_ACCESS_CTRL_STATS_EN
    ,
    output logic [15:0]   stat_acc0,
    output logic [15:0]   stat_acc1,
    output logic [15:0]   stat_conflict
`endif
);

    state_e        state_q;
    logic          last_grant_q;
    logic          owner_q;
    logic [2:0]    op_q;
    logic [1:0]    off_q;
    logic [DW-1:0] wdata_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_din_q;
    logic          mem_we_q;
    logic [1:0]    rsp_valid_q;
    logic [DW-1:0] rsp_rdata_q;
    logic          rsp_err_q;

    logic          grant;
    logic          accept;
    logic [1:0]    grant_oh;
    logic [1:0]    owner_oh;
    logic [AW-1:0] sel_addr;
    logic [2:0]    sel_op;
    logic [DW-1:0] sel_wdata;
    logic [AW-1:0] word_addr;
    logic [DW-1:0] load_word;
    logic [DW-1:0] store_word;

    // Round-robin: under contention the port that did not win last time wins.
    always_comb begin
        grant = 1'b0;
        if (req_valid == 2'b11) begin
            grant = ~last_grant_q;
        end else if (req_valid[1]) begin
            grant = 1'b1;
        end
    end

    assign accept    = (state_q == IDLE) && (|req_valid) && !rst;
    assign grant_oh  = grant ? 2'b10 : 2'b01;
    assign owner_oh  = owner_q ? 2'b10 : 2'b01;
    assign sel_addr  = grant ? req_addr1 : req_addr0;
    assign sel_op    = grant ? req_op1 : req_op0;
    assign sel_wdata = grant ? req_wdata1 : req_wdata0;
    assign word_addr = {sel_addr[AW-1:2], 2'b00};

    dm_lane_mux u_lane_mux (
        .op_i    (op_q),
        .off_i   (off_q),
        .word_i  (mem_dout),
        .wdata_i (wdata_q),
        .load_o  (load_word),
        .store_o (store_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            op_q         <= OP_LW;
            off_q        <= 2'b00;
            wdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            mem_we_q     <= 1'b0;
            rsp_valid_q  <= 2'b00;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            // Response and write strobes are single-cycle pulses by default.
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        owner_q      <= grant;
                        last_grant_q <= grant;
                        op_q         <= sel_op;
                        off_q        <= sel_addr[1:0];
                        wdata_q      <= sel_wdata;
                        if (is_misaligned(sel_op, sel_addr[1:0])) begin
                            state_q     <= RSP;
                            rsp_valid_q <= grant_oh;
                            rsp_err_q   <= 1'b1;
                        end else if (sel_op == OP_SW) begin
                            state_q    <= WR;
                            mem_addr_q <= word_addr;
                            mem_din_q  <= sel_wdata;
                            mem_we_q   <= 1'b1;
                        end else begin
                            // Loads and sub-word stores both need the current word.
                            state_q    <= RD;
                            mem_addr_q <= word_addr;
                        end
                    end
                end
                RD: begin
                    if (is_store(op_q)) begin
                        state_q   <= WR;
                        mem_din_q <= store_word;
                        mem_we_q  <= 1'b1;
                    end else begin
                        state_q     <= RSP;
                        rsp_valid_q <= owner_oh;
                        rsp_rdata_q <= load_word;
                        mem_addr_q  <= '0;
                    end
                end
                WR: begin
                    state_q     <= RSP;
                    rsp_valid_q <= owner_oh;
                    mem_addr_q  <= '0;
                end
                RSP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = accept ? grant_oh : 2'b00;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    // A reset landing on the WR cycle must not corrupt the target word.
    assign mem_we    = mem_we_q & ~rst;
    assign dbg_state = state_q;

`ifdef DM_ACCESS_CTRL_STATS_EN
    logic [15:0] acc0_q;
    logic [15:0] acc1_q;
    logic [15:0] conflict_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc0_q     <= '0;
            acc1_q     <= '0;
            conflict_q <= '0;
        end else begin
            if ((state_q == RSP) && !owner_q && (acc0_q != 16'hFFFF)) begin
                acc0_q <= acc0_q + 16'd1;
            end
            if ((state_q == RSP) && owner_q && (acc1_q != 16'hFFFF)) begin
                acc1_q <= acc1_q + 16'd1;
            end
            if ((state_q == IDLE) && (req_valid == 2'b11) && (conflict_q != 16'hFFFF)) begin
                conflict_q <= conflict_q + 16'd1;
            end
        end
    end

    assign stat_acc0     = acc0_q;
    assign stat_acc1     = acc1_q;
    assign stat_conflict = conflict_q;
`endif

endmodule

// File: tb/tb_dm_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dm_access_ctrl
// Directed bench for dm_access_ctrl with a behavioural 1 KB word memory.
// Drivers push the expected response (port, data, error, cycle) into exp_q
// when a request is accepted; a monitor pops and compares on rsp_valid.
// -----------------------------------------------------------------------------
module tb_dm_access_ctrl;
    import dm_access_pkg::*;

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [9:0]  req_addr0 = '0;
    logic [9:0]  req_addr1 = '0;
    logic [2:0]  req_op0 = '0;
    logic [2:0]  req_op1 = '0;
    logic [31:0] req_wdata0 = '0;
    logic [31:0] req_wdata1 = '0;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din;
    logic        mem_we;
    logic [31:0] mem_dout;
    logic [1:0]  dbg_state;
`ifdef DM_ACCESS_CTRL_STATS_EN
    logic [15:0] stat_acc0;
    logic [15:0] stat_acc1;
    logic [15:0] stat_conflict;
`endif

    logic [31:0] mem [256];
    exp_t        exp_q[$];
    int          grant_log[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          we_cnt = 0;

    dm_access_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_op0    (req_op0),
        .req_op1    (req_op1),
        .req_wdata0 (req_wdata0),
        .req_wdata1 (req_wdata1),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_we     (mem_we),
        .mem_dout   (mem_dout),
        .dbg_state  (dbg_state)
`ifdef DM_ACCESS_CTRL_STATS_EN
        ,
        .stat_acc0     (stat_acc0),
        .stat_acc1     (stat_acc1),
        .stat_conflict (stat_conflict)
`endif
    );

    // ---------------- clock / reset / memory model ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_dout = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:2]] <= mem_din;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", name, got, want);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Present one request on a port until accepted; optionally push the
    // expected response. Inputs are scrambled after acceptance.
    task automatic issue(input int port, input logic [2:0] op, input logic [9:0] addr,
                         input logic [31:0] wdata, input logic [31:0] erd, input logic eerr,
                         input int lat, input bit push);
        exp_t e;
        bit   got;
        got = 1'b0;
        @(posedge clk); #1;
        if (port == 0) begin
            req_addr0 = addr; req_op0 = op; req_wdata0 = wdata;
        end else begin
            req_addr1 = addr; req_op1 = op; req_wdata1 = wdata;
        end
        req_valid[port] = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (req_ready[port]) begin
                got = 1'b1;
                if (push) begin
                    e.valid = (port == 0) ? 2'b01 : 2'b10;
                    e.rdata = erd;
                    e.err   = eerr;
                    e.cyc   = cyc + lat;
                    exp_q.push_back(e);
                end
            end
        end
        @(posedge clk); #1;
        req_valid[port] = 1'b0;
        if (port == 0) begin
            req_addr0 = 10'($urandom_range(0, 1023)); req_op0 = 3'($urandom_range(0, 7));
            req_wdata0 = $urandom;
        end else begin
            req_addr1 = 10'($urandom_range(0, 1023)); req_op1 = 3'($urandom_range(0, 7));
            req_wdata1 = $urandom;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL grant_timeout: port %0d got no req_ready want a grant", port);
        end
    endtask

    task automatic wait_idle();
        bool_loop: for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL rsp_timeout: got %0d pending responses want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_we === 1'b1) we_cnt++;
            if (req_ready[0] === 1'b1) grant_log.push_back(0);
            if (req_ready[1] === 1'b1) grant_log.push_back(1);
            if (rsp_valid !== 2'b00 && rsp_valid !== 2'bxx) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_rsp: got rsp_valid=%b want none", rsp_valid);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_port", 32'(rsp_valid), 32'(e.valid));
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                    check("rsp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int we0;
        logic [31:0] w;

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = 32'hDEAD_BEEF;
        mem[1] = 32'hCAFE_F00D;
        mem[4] = 32'h8070_F0A5;
        mem[8] = 32'h1122_3344;

        // reset state
        do_reset();
        @(negedge clk);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_din", mem_din, 32'h0);

        // sub-word loads, response at T+2
        issue(0, OP_LB,  10'h010, 32'h0, 32'hFFFF_FFA5, 1'b0, 2, 1'b1); wait_idle();
        issue(0, OP_LBU, 10'h011, 32'h0, 32'h0000_00F0, 1'b0, 2, 1'b1); wait_idle();
        issue(0, OP_LH,  10'h012, 32'h0, 32'hFFFF_8070, 1'b0, 2, 1'b1); wait_idle();
        issue(0, OP_LHU, 10'h010, 32'h0, 32'h0000_F0A5, 1'b0, 2, 1'b1); wait_idle();
        issue(0, OP_LW,  10'h010, 32'h0, 32'h8070_F0A5, 1'b0, 2, 1'b1); wait_idle();

        // read-modify-write stores, response at T+3, one write each
        we0 = we_cnt;
        issue(0, OP_SB, 10'h013, 32'hFFFF_FF3C, 32'h0, 1'b0, 3, 1'b1); wait_idle();
        check("sb_we_count", 32'(we_cnt - we0), 32'd1);
        check("sb_word", mem[4], 32'h3C70_F0A5);
        we0 = we_cnt;
        issue(0, OP_SH, 10'h010, 32'hABCD_1234, 32'h0, 1'b0, 3, 1'b1); wait_idle();
        check("sh_we_count", 32'(we_cnt - we0), 32'd1);
        check("sh_word", mem[4], 32'h3C70_1234);

        // misaligned: error at T+1, no memory write
        we0 = we_cnt;
        issue(0, OP_LW, 10'h002, 32'h0, 32'h0, 1'b1, 1, 1'b1); wait_idle();
        issue(0, OP_LH, 10'h005, 32'h0, 32'h0, 1'b1, 1, 1'b1); wait_idle();
        issue(1, OP_SW, 10'h001, 32'h5555_5555, 32'h0, 1'b1, 1, 1'b1); wait_idle();
        check("misalign_we_count", 32'(we_cnt - we0), 32'd0);
        check("misalign_word0", mem[0], 32'hDEAD_BEEF);
        check("misalign_word1", mem[1], 32'hCAFE_F00D);

        // contention from reset: grants alternate 0,1,0,1
        do_reset();
        grant_log.delete();
        fork
            begin
                issue(0, OP_SW, 10'h040, 32'hA000_0001, 32'h0, 1'b0, 2, 1'b1);
                issue(0, OP_SW, 10'h048, 32'hA000_0002, 32'h0, 1'b0, 2, 1'b1);
            end
            begin
                issue(1, OP_SW, 10'h044, 32'hB000_0001, 32'h0, 1'b0, 2, 1'b1);
                issue(1, OP_SW, 10'h04C, 32'hB000_0002, 32'h0, 1'b0, 2, 1'b1);
            end
        join
        wait_idle();
        check("grant_count", 32'(grant_log.size()), 32'd4);
        if (grant_log.size() == 4) begin
            check("grant_0", 32'(grant_log[0]), 32'd0);
            check("grant_1", 32'(grant_log[1]), 32'd1);
            check("grant_2", 32'(grant_log[2]), 32'd0);
            check("grant_3", 32'(grant_log[3]), 32'd1);
        end
        check("sw_word_40", mem[16], 32'hA000_0001);
        check("sw_word_44", mem[17], 32'hB000_0001);
        check("sw_word_48", mem[18], 32'hA000_0002);
        check("sw_word_4c", mem[19], 32'hB000_0002);

        // reset during the WR cycle of an SB
        we0 = we_cnt;
        issue(0, OP_SB, 10'h021, 32'h0000_00EE, 32'h0, 1'b0, 3, 1'b0);
        // issue returns one cycle after accept (RD); next cycle is WR
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rstwr_state_wr", 32'(dbg_state), 32'(WR));
        check("rstwr_mem_we", 32'(mem_we), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstwr_state_idle", 32'(dbg_state), 32'(IDLE));
        check("rstwr_rsp_valid", 32'(rsp_valid), 32'h0);
        repeat (3) @(negedge clk);
        check("rstwr_we_count", 32'(we_cnt - we0), 32'd0);
        check("rstwr_word", mem[8], 32'h1122_3344);

`ifdef DM_ACCESS_CTRL_STATS_EN
        do_reset();
        w = mem[4];
        fork
            issue(0, OP_LW, 10'h010, 32'h0, w, 1'b0, 2, 1'b1);
            issue(1, OP_LW, 10'h010, 32'h0, w, 1'b0, 2, 1'b1);
        join
        wait_idle();
        fork
            issue(0, OP_LBU, 10'h011, 32'h0, {24'h0, w[15:8]}, 1'b0, 2, 1'b1);
            issue(1, OP_LW, 10'h003, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        join
        wait_idle();
        issue(0, OP_LHU, 10'h012, 32'h0, {16'h0, w[31:16]}, 1'b0, 2, 1'b1);
        wait_idle();
        repeat (2) @(negedge clk);
        check("stat_acc0", 32'(stat_acc0), 32'd3);
        check("stat_acc1", 32'(stat_acc1), 32'd2);
        check("stat_conflict", 32'(stat_conflict), 32'd2);
`else
        w = 32'h0;
`endif

        repeat (3) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
